// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-source round-robin select arbiter.
package rr_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Bundle of source requests, downstream ready and the arbiter's select/grant outputs.
interface rr_sel_arbiter_if;
    import rr_arb_pkg::*;

    // Handshake: a beat transfers on any cycle where out_valid and ready_out are
    // both high; src_ready[i] tells source i its beat was consumed that cycle.
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] last;
    logic               ready_out;
    logic [NUM_SRC-1:0] src_ready;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] gnt;
    logic               out_valid;
    logic               out_last;
    logic               overrun;

    modport master (
        input  req, last, ready_out,
        output src_ready, sel, gnt, out_valid, out_last, overrun
    );

    modport slave (
        output req, last, ready_out,
        input  src_ready, sel, gnt, out_valid, out_last, overrun
    );

endinterface

// File: rtl/rr_pick4.sv
// Round-robin pick: first requesting source scanning ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin burst arbiter driving a downstream 4:1 mux select; no data path.
module rr_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    rr_sel_arbiter_if.master bus,
    output state_t           dbg_state,
    output logic [SEL_W-1:0] dbg_ptr
);

    localparam int              CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [NUM_SRC-1:0] gnt_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               req_sel;
    logic               last_sel;
    logic               in_grant;
    logic               beat;
    logic               at_max;
    logic               release_now;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        req_sel     = bus.req[sel_q];
        last_sel    = bus.last[sel_q];
        in_grant    = (state == GRANT);
        beat        = in_grant && req_sel && bus.ready_out;
        at_max      = (cnt_q == CNT_MAX);
        release_now = beat && (last_sel || at_max);
    end

    // Outputs are forced quiet while rst is high so an abandoned burst never leaks a beat.
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = !rst && in_grant && req_sel;
    assign bus.out_last  = !rst && in_grant && req_sel && last_sel;
    assign bus.src_ready = rst ? '0 : (gnt_q & {NUM_SRC{bus.ready_out}});
    assign bus.overrun   = !rst && beat && at_max && !last_sel;

    assign dbg_state = state;
    assign dbg_ptr   = ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr_q <= SEL_W'(NUM_SRC - 1);
            sel_q <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel_q <= pick_idx;
                        gnt_q <= onehot(pick_idx);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        if (release_now) begin
                            ptr_q <= sel_q;
                            gnt_q <= '0;
                            cnt_q <= '0;
                            state <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
